// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point add dispatcher.
package fp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone,
        StDrain
    } disp_state_e;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    function automatic logic [31:0] fp_negate(input logic [31:0] x);
        return {~x[31], x[30:0]};
    endfunction

endpackage

// File: rtl/fp_dispatch_fifo.sv
// Request FIFO for the add dispatcher; extra pointer MSB tells full from empty.
module fp_dispatch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fp_add_dispatch.sv
// Queues FP add requests and feeds them one at a time to an external adder.
// Define FP_DISPATCH_SUB_EN to turn sub=1 requests into A + (-B).
module fp_add_dispatch
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      add_op1,
    output logic [31:0]      add_op2,
    output logic             add_valid,
    input  logic [31:0]      add_result,
    input  logic             add_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

`ifdef FP_DISPATCH_SUB_EN
    localparam int unsigned FW = 65 + TAG_W;
`else
    localparam int unsigned FW = 64 + TAG_W;
`endif

    logic [FW-1:0]    fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [31:0]      head_op1, head_op2, head_op2_eff;
    logic [TAG_W-1:0] head_tag;

`ifdef FP_DISPATCH_SUB_EN
    logic head_sub;
    assign fifo_wdata   = {in_op1, in_op2, in_sub, in_tag};
    assign {head_op1, head_op2, head_sub, head_tag} = fifo_rdata;
    assign head_op2_eff = head_sub ? fp_negate(head_op2) : head_op2;
`else
    logic unused_sub;
    assign unused_sub   = in_sub;
    assign fifo_wdata   = {in_op1, in_op2, in_tag};
    assign {head_op1, head_op2, head_tag} = fifo_rdata;
    assign head_op2_eff = head_op2;
`endif

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    fp_dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    disp_state_e      state_q, state_d;
    logic [31:0]      op1_q, op1_d, op2_q, op2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_q, res_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             out_valid_q, out_valid_d;
    logic             out_pop, can_capture, capture;

    assign add_valid  = (state_q == StIssue) || (state_q == StWaitDone);
    assign add_op1    = add_valid ? op1_q : '0;
    assign add_op2    = add_valid ? op2_q : '0;
    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_tag    = res_tag_q;

    assign out_pop     = out_valid_q && out_ready;
    assign can_capture = !out_valid_q || out_pop;

    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        tag_d       = tag_q;
        res_d       = res_q;
        res_tag_d   = res_tag_q;
        out_valid_d = out_valid_q;
        fifo_pop    = 1'b0;
        capture     = 1'b0;

        if (out_pop) out_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op1_d    = head_op1;
                    op2_d    = head_op2_eff;
                    tag_d    = head_tag;
                    state_d  = StIssue;
                end
            end
            StIssue, StWaitDone: begin
                if (add_done && can_capture) begin
                    capture = 1'b1;
                    state_d = StDrain;
                end else begin
                    state_d = StWaitDone;
                end
            end
            // A lingering add_done from the last op must not complete the next one.
            StDrain: begin
                if (!add_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            res_d       = add_result;
            res_tag_d   = tag_q;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            op1_q       <= '0;
            op2_q       <= '0;
            tag_q       <= '0;
            res_q       <= '0;
            res_tag_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            tag_q       <= tag_d;
            res_q       <= res_d;
            res_tag_q   <= res_tag_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
